// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared control-path types for the instruction fetch unit: fetch FSM
// encoding, the NOP instruction word and the PC step size.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  // Fetch FSM states: idle, request outstanding, waiting for read data.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;

  // ADDI x0, x0, 0 -- the canonical RISC-V NOP held in inst out of reset.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Sequential fetch advances by one 32-bit word.
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage : inst_fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit: issues one memory read per fetch_req at the current
// PC, latches the returned word into the instruction register and advances
// the PC (or applies a redirect captured while the fetch was in flight).
// Optional macro FETCH_MISALIGN_CHECK_EN: refuse fetches from a PC with
// non-zero low bits and raise a sticky misalign_err instead.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_old,
  output logic        fetch_busy,
  output logic        misalign_err
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_old_q;
  logic [31:0]  inst_q;
  logic         inst_valid_q;
  logic         pend_valid_q;
  logic [31:0]  pend_pc_q;
  logic [31:0]  pc_done_d;
  logic         fetch_blocked;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign fetch_blocked = (pc_q[1:0] != 2'b00);
  assign misalign_err  = misalign_q;

  // Sticky misalignment flag: set by a refused fetch, cleared by any PC load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (pc_load) begin
      misalign_q <= 1'b0;
    end else if ((state_q == FETCH_IDLE) && fetch_req && fetch_blocked) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign fetch_blocked = 1'b0;
  assign misalign_err  = 1'b0;
`endif

  assign mem_req    = (state_q == FETCH_REQ);
  assign mem_addr   = {pc_q[31:2], 2'b00};
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_old     = pc_old_q;
  assign fetch_busy = (state_q != FETCH_IDLE);

  // PC taken on fetch completion: a same-cycle load beats an earlier pending
  // redirect, which beats the sequential increment.
  always_comb begin
    pc_done_d = pc_q + PC_STEP;
    if (pc_load) begin
      pc_done_d = pc_next;
    end else if (pend_valid_q) begin
      pc_done_d = pend_pc_q;
    end
  end

  // Fetch FSM with registered PC, instruction and redirect state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      pc_old_q     <= 32'h0000_0000;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (pc_load) begin
            pc_q <= pc_next;
          end
          if (fetch_req) begin
            inst_valid_q <= 1'b0;
          end
          if (fetch_req && !fetch_blocked) begin
            state_q <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (pc_load) begin
            pend_valid_q <= 1'b1;
            pend_pc_q    <= pc_next;
          end
          if (mem_ready) begin
            state_q <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            inst_q       <= mem_rdata;
            pc_old_q     <= pc_q;
            pc_q         <= pc_done_d;
            inst_valid_q <= 1'b1;
            pend_valid_q <= 1'b0;
            state_q      <= FETCH_IDLE;
          end else if (pc_load) begin
            pend_valid_q <= 1'b1;
            pend_pc_q    <= pc_next;
          end
        end
        default: begin
          state_q <= FETCH_IDLE;
        end
      endcase
    end
  end

endmodule : inst_fetch

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_old;
  logic        fetch_busy;
  logic        misalign_err;

  int tests_run;
  int tests_failed;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .pc_old       (pc_old),
    .fetch_busy   (fetch_busy),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic        ld;
    logic [31:0] nxt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_mreq;
    logic        e_busy;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pold;
  } vec_t;

  vec_t vec [16];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    pc_load    = 1'b0;
    pc_next    = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Transaction-level reference model.
  logic        m_open, m_acc, m_redir, m_iv, m_err;
  logic [31:0] m_pc, m_pc_old, m_inst, m_redir_pc;

  task automatic model_reset();
    m_open = 1'b0; m_acc = 1'b0; m_redir = 1'b0; m_iv = 1'b0; m_err = 1'b0;
    m_pc = RST_PC; m_pc_old = 32'h0; m_inst = NOP; m_redir_pc = 32'h0;
  endtask

  task automatic model_step(input logic fr, input logic ld, input logic [31:0] nxt,
                            input logic rdy, input logic rv, input logic [31:0] rd);
    logic ok;
    ok = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    ok = (m_pc % 4 == 0);
`endif
    if (!m_open) begin
      if (fr) m_iv = 1'b0;
      if (fr && ok) begin
        m_open = 1'b1; m_acc = 1'b0; m_redir = 1'b0;
      end
      if (fr && !ok) m_err = 1'b1;
      if (ld) m_pc = nxt;
    end else begin
      if (ld) begin
        m_redir = 1'b1; m_redir_pc = nxt;
      end
      if (!m_acc) begin
        if (rdy) m_acc = 1'b1;
      end else if (rv) begin
        m_inst   = rd;
        m_pc_old = m_pc;
        m_pc     = m_redir ? m_redir_pc : m_pc + 32'd4;
        m_iv     = 1'b1;
        m_open   = 1'b0;
      end
    end
    if (ld) m_err = 1'b0;
  endtask

  logic        r_fr, r_ld, r_rdy, r_rv;
  logic [31:0] r_nxt, r_rd;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle_inputs();

    //                fr    ld    nxt       rdy   rv    rdata          mreq  busy  iv    pc        addr      inst           pc_old
    vec[0]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,    32'h0,    NOP,           32'h0};
    vec[1]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,    32'h0,    NOP,           32'h0};
    vec[2]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h00500093,  1'b0, 1'b0, 1'b1, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[3]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[4]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[5]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[6]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[7]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[8]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h4,    32'h4,    32'h00500093,  32'h0};
    vec[10] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'hA1A2A3A4,  1'b0, 1'b0, 1'b1, 32'h8,    32'h8,    32'hA1A2A3A4,  32'h4};
    vec[11] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h8,    32'h8,    32'hA1A2A3A4,  32'h4};
    vec[12] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h8,    32'h8,    32'hA1A2A3A4,  32'h4};
    vec[13] = '{1'b0, 1'b1, 32'h100,  1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h8,    32'h8,    32'hA1A2A3A4,  32'h4};
    vec[14] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h11111111,  1'b0, 1'b0, 1'b1, 32'h100,  32'h100,  32'h11111111,  32'h8};
    vec[15] = '{1'b0, 1'b1, 32'h200,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h200,  32'h200,  32'h11111111,  32'h8};

    // Reset state.
    do_reset();
    chk1 ("rst.mem_req",    mem_req,      1'b0);
    chk1 ("rst.busy",       fetch_busy,   1'b0);
    chk1 ("rst.inst_valid", inst_valid,   1'b0);
    chk1 ("rst.misalign",   misalign_err, 1'b0);
    chk32("rst.pc",         pc,           RST_PC);
    chk32("rst.pc_old",     pc_old,       32'h0);
    chk32("rst.inst",       inst,         NOP);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      fetch_req  = vec[i].fr;
      pc_load    = vec[i].ld;
      pc_next    = vec[i].nxt;
      mem_ready  = vec[i].rdy;
      mem_rvalid = vec[i].rv;
      mem_rdata  = vec[i].rdata;
      step();
      chk1 ($sformatf("v%0d.mem_req", i),    mem_req,    vec[i].e_mreq);
      chk1 ($sformatf("v%0d.busy", i),       fetch_busy, vec[i].e_busy);
      chk1 ($sformatf("v%0d.inst_valid", i), inst_valid, vec[i].e_iv);
      chk32($sformatf("v%0d.pc", i),         pc,         vec[i].e_pc);
      chk32($sformatf("v%0d.mem_addr", i),   mem_addr,   vec[i].e_addr);
      chk32($sformatf("v%0d.inst", i),       inst,       vec[i].e_inst);
      chk32($sformatf("v%0d.pc_old", i),     pc_old,     vec[i].e_pold);
    end
    idle_inputs();

    // PC wrap at the top of the address space.
    pc_load = 1'b1; pc_next = 32'hFFFF_FFFC; step();
    pc_load = 1'b0; fetch_req = 1'b1; mem_ready = 1'b1; step();
    chk32("wrap.mem_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    fetch_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0022; step();
    mem_rvalid = 1'b0;
    chk32("wrap.pc",     pc,     32'h0);
    chk32("wrap.pc_old", pc_old, 32'hFFFF_FFFC);
    chk32("wrap.inst",   inst,   32'h0000_0022);

    // Two redirects while a fetch is in flight: the later one wins.
    fetch_req = 1'b1; step();
    fetch_req = 1'b0; pc_load = 1'b1; pc_next = 32'h300; step();
    pc_next = 32'h400; mem_ready = 1'b1; step();
    pc_load = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33; step();
    idle_inputs();
    chk32("redir.pc",     pc,     32'h400);
    chk32("redir.pc_old", pc_old, 32'h0);

    // Reset asserted during WAIT, stale rvalid afterwards.
    fetch_req = 1'b1; mem_ready = 1'b1; step();
    step();
    idle_inputs();
    chk1("rstmid.busy_before", fetch_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1 ("rstmid.async_busy", fetch_busy, 1'b0);
    chk32("rstmid.async_pc",   pc,         RST_PC);
    step();
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0000; step();
    mem_rvalid = 1'b0; step();
    chk32("rstmid.inst",       inst,       NOP);
    chk1 ("rstmid.inst_valid", inst_valid, 1'b0);
    chk32("rstmid.pc",         pc,         RST_PC);
    chk1 ("rstmid.busy",       fetch_busy, 1'b0);

    // Misaligned PC handling.
    pc_load = 1'b1; pc_next = 32'h102; step();
    pc_load = 1'b0; fetch_req = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("mis%0d.err", i),     misalign_err, 1'b1);
      chk1($sformatf("mis%0d.mem_req", i), mem_req,      1'b0);
      chk1($sformatf("mis%0d.busy", i),    fetch_busy,   1'b0);
    end
    fetch_req = 1'b0; pc_load = 1'b1; pc_next = 32'h104; step();
    pc_load = 1'b0;
    chk1 ("mis.err_cleared", misalign_err, 1'b0);
    chk32("mis.pc",          pc,           32'h104);
`else
    step();
    chk1 ("mis.mem_req",  mem_req,      1'b1);
    chk32("mis.mem_addr", mem_addr,     32'h100);
    chk1 ("mis.err",      misalign_err, 1'b0);
    fetch_req = 1'b0; mem_ready = 1'b1; step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44; step();
    mem_rvalid = 1'b0;
    chk32("mis.pc",     pc,     32'h106);
    chk32("mis.pc_old", pc_old, 32'h102);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      r_fr  = ($urandom_range(0, 2) != 0);
      r_ld  = ($urandom_range(0, 9) == 0);
      r_nxt = $urandom();
      if ($urandom_range(0, 7) != 0) r_nxt[1:0] = 2'b00;
      r_rdy = ($urandom_range(0, 4) < 3);
      r_rv  = ($urandom_range(0, 9) < 3);
      r_rd  = $urandom();
      fetch_req = r_fr; pc_load = r_ld; pc_next = r_nxt;
      mem_ready = r_rdy; mem_rvalid = r_rv; mem_rdata = r_rd;
      model_step(r_fr, r_ld, r_nxt, r_rdy, r_rv, r_rd);
      step();
      chk1 ($sformatf("rnd%0d.mem_req", c),    mem_req,      m_open && !m_acc);
      chk1 ($sformatf("rnd%0d.busy", c),       fetch_busy,   m_open);
      chk1 ($sformatf("rnd%0d.inst_valid", c), inst_valid,   m_iv);
      chk1 ($sformatf("rnd%0d.misalign", c),   misalign_err, m_err);
      chk32($sformatf("rnd%0d.pc", c),         pc,           m_pc);
      chk32($sformatf("rnd%0d.pc_old", c),     pc_old,       m_pc_old);
      chk32($sformatf("rnd%0d.inst", c),       inst,         m_inst);
      chk32($sformatf("rnd%0d.mem_addr", c),   mem_addr,     m_pc & 32'hFFFF_FFFC);
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_inst_fetch

`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-low; low clears all state immediately.
- REQ-004: fetch_req  input  1  level request from control FSM to fetch the instruction at pc.
- REQ-005: pc_load  input  1  one-cycle pulse from control (pc_en); load pc_next into pc.
- REQ-006: pc_next  input  32  new PC value (ALU/result path).
- REQ-007: mem_req  output  1  memory read request; held until accepted.
- REQ-008: mem_addr  output  32  word address of the request.
- REQ-009: mem_ready  input  1  memory accepts request when mem_req && mem_ready.
- REQ-010: mem_rvalid  input  1  read data valid, one cycle, at least 1 cycle after acceptance.
- REQ-011: mem_rdata  input  32  instruction word.
- REQ-012: inst  output  32  instruction register, drives control inst input.
- REQ-013: inst_valid  output  1  inst holds a freshly fetched word; clears on next fetch_req.
- REQ-014: pc  output  32  current PC.
- REQ-015: pc_old  output  32  PC of the instruction held in inst.
- REQ-016: fetch_busy  output  1  high in any state other than IDLE.
- REQ-017: misalign_err  output  1  misaligned fetch detected (see Configuration).

Function
- REQ-018: FSM states IDLE, REQ, WAIT; encoding in shared package.
- REQ-019: IDLE: fetch_req=1 and no error -> REQ; inst_valid cleared same edge.
- REQ-020: REQ: mem_req=1, mem_addr=pc; mem_ready=1 -> WAIT; otherwise stay, address stable.
- REQ-021: WAIT: mem_rvalid=1 -> inst<=mem_rdata, pc_old<=pc, pc<=pc+4 (mod 2^32), inst_valid<=1, -> IDLE.
- REQ-022: mem_rvalid outside WAIT is ignored.
- REQ-023: Minimum fetch latency: fetch_req rising in IDLE to inst_valid high = 3 cycles with mem_ready=1 and mem_rvalid the cycle after acceptance.
- REQ-024: pc_load in IDLE: pc<=pc_next next edge; has priority over any increment.
- REQ-025: pc_load in REQ/WAIT: pc_next captured in a pending register; applied on WAIT->IDLE edge instead of pc+4; pc_old still takes pre-fetch pc.
- REQ-026: Second pc_load while pending: latest value wins.
- REQ-027: PC wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000 silently.
- REQ-028: inst and pc_old hold value until next completed fetch.

Reset
- REQ-029: On reset low: state=IDLE, pc=RESET_PC, pc_old=0, inst=32'h0000_0013 (NOP), inst_valid=0, mem_req=0, misalign_err=0, pending cleared.
- REQ-030: Reset mid-fetch abandons the transaction; a late mem_rvalid after reset release is ignored (state is IDLE).

Configuration
- REQ-031: Macro FETCH_MISALIGN_CHECK_EN.
- REQ-032: Defined: fetch_req in IDLE with pc[1:0]!=0 -> no mem_req, stay IDLE, misalign_err<=1 (sticky); cleared by pc_load or reset.
- REQ-033: Undefined: misalign_err tied 0; mem_addr={pc[31:2],2'b00}.

Structure
- REQ-034: fetch_state_t enum and NOP_INST constant in the shared control package alongside existing ctrl typedefs.
- REQ-035: Single module; no sub-modules.

Verification
- REQ-036: Reset release, fetch_req=1, mem_ready=1, rvalid next cycle with rdata=32'h00500093 -> inst=32'h00500093, pc_old=0, pc=4, inst_valid at cycle 3.
- REQ-037: mem_ready low 4 cycles -> mem_req and mem_addr stable 5 cycles, single fetch completes.
- REQ-038: pc_load with pc_next=32'h100 during WAIT -> after completion pc=32'h100, pc_old=pre-fetch pc.
- REQ-039: pc=32'hFFFF_FFFC fetch -> pc=0 after completion.
- REQ-040: With macro, pc_load pc_next=32'h102 then fetch_req -> misalign_err=1, mem_req never asserts; pc_load 32'h104 clears it.
- REQ-041: Reset asserted in WAIT, mem_rvalid pulsed after release -> inst=NOP, inst_valid=0, pc=RESET_PC.
